// File: rtl/scan_comm_receiver.sv
// Purpose: synchronise, debounce and decode the peer scanner comm code into pulses, level, error flag and event count.
// Latency: a code stable before edge N is accepted at edge N+STABLE_CYCLES+1; all outputs are registered.
// Backpressure: none; the peer code is sampled every cycle. SCAN_COMM_EVENT_COUNT_EN builds the event counter.
module scan_comm_receiver #(
    parameter int unsigned STABLE_CYCLES = 2,
    parameter int unsigned COUNT_WIDTH   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             peer_comm,
    input  logic                   clear_error,
    output logic                   go_to_standby_pulse,
    output logic                   start_scan_pulse,
    output logic                   flush_pulse,
    output logic                   ready_to_transfer,
    output logic [1:0]             accepted_code,
    output logic                   proto_error,
    output logic [COUNT_WIDTH-1:0] event_count
);

    localparam logic [1:0] CODE_INACTIVE = 2'b00;
    localparam logic [1:0] CODE_STANDBY  = 2'b01;
    localparam logic [1:0] CODE_SCAN     = 2'b10;
    localparam logic [1:0] CODE_FLUSH    = 2'b11;

    localparam int unsigned   STAB_W   = 4;
    localparam logic [STAB_W-1:0] STAB_MAX = '1;
    localparam logic [STAB_W-1:0] STAB_THR = STAB_W'(STABLE_CYCLES);

    logic [1:0]        sync1_q, sync2_q;
    logic [1:0]        cand_q, cand_d;
    logic [STAB_W-1:0] stab_q, stab_d;
    logic [1:0]        acc_q, acc_d;
    logic              accept;
    logic              go_q, go_d;
    logic              scan_q, scan_d;
    logic              flush_q, flush_d;
    logic              err_q, err_d;

    function automatic logic is_legal(input logic [1:0] from_code, input logic [1:0] to_code);
        logic legal;
        legal = 1'b0;
        case ({from_code, to_code})
            {CODE_INACTIVE, CODE_STANDBY},
            {CODE_STANDBY,  CODE_SCAN},
            {CODE_STANDBY,  CODE_INACTIVE},
            {CODE_SCAN,     CODE_FLUSH},
            {CODE_SCAN,     CODE_INACTIVE},
            {CODE_FLUSH,    CODE_INACTIVE}: legal = 1'b1;
            default:                        legal = 1'b0;
        endcase
        return legal;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= CODE_INACTIVE;
            sync2_q <= CODE_INACTIVE;
        end else begin
            sync1_q <= peer_comm;
            sync2_q <= sync1_q;
        end
    end

    // Stability count includes the current cycle, so STABLE_CYCLES=1 accepts the cycle the candidate is loaded.
    always_comb begin
        cand_d = sync2_q;
        stab_d = 4'd1;
        if (sync2_q == cand_q) begin
            stab_d = (stab_q == STAB_MAX) ? STAB_MAX : stab_q + 4'd1;
        end
    end

    assign accept = (stab_d >= STAB_THR) && (cand_d != acc_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cand_q <= CODE_INACTIVE;
            stab_q <= '0;
        end else begin
            cand_q <= cand_d;
            stab_q <= stab_d;
        end
    end

    // Accepted code: state register / next-state / output processes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= CODE_INACTIVE;
        end else begin
            acc_q <= acc_d;
        end
    end

    always_comb begin
        acc_d = acc_q;
        if (accept) begin
            acc_d = cand_d;
        end
    end

    always_comb begin
        go_d    = 1'b0;
        scan_d  = 1'b0;
        flush_d = 1'b0;
        err_d   = err_q;
        if (clear_error) begin
            err_d = 1'b0;
        end
        if (accept) begin
            go_d    = (cand_d == CODE_STANDBY);
            scan_d  = (cand_d == CODE_SCAN);
            flush_d = (cand_d == CODE_FLUSH);
            if (!is_legal(acc_q, cand_d)) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            go_q    <= 1'b0;
            scan_q  <= 1'b0;
            flush_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            go_q    <= go_d;
            scan_q  <= scan_d;
            flush_q <= flush_d;
            err_q   <= err_d;
        end
    end

`ifdef SCAN_COMM_EVENT_COUNT_EN
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (accept && (cnt_q != {COUNT_WIDTH{1'b1}})) begin
            cnt_d = cnt_q + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign event_count = cnt_q;
`else
    assign event_count = '0;
`endif

    assign go_to_standby_pulse = go_q;
    assign start_scan_pulse    = scan_q;
    assign flush_pulse         = flush_q;
    assign ready_to_transfer   = (acc_q == CODE_STANDBY);
    assign accepted_code       = acc_q;
    assign proto_error         = err_q;

    a_pulse_onehot: assert property (@(posedge clk) disable iff (!reset)
        $onehot0({go_q, scan_q, flush_q}));

endmodule

// File: doc/scan_comm_receiver.md
SCAN_COMM_RECEIVER -- requirements
Module: scan_comm_receiver

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 2, meaning consecutive cycles a synchronized code must hold before acceptance (legal range 1-15).
REQ-002 SHALL have parameter COUNT_WIDTH, default 4, meaning width of event_count.
REQ-003 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port peer_comm  input  2  asynchronous comm code from peer scanner: 00 INACTIVE, 01 GO_TO_STANDBY/READY_TO_TRANSFER, 10 START_SCAN, 11 START_FLUSH.
REQ-006 SHALL have port clear_error  input  1  synchronous clear of proto_error.
REQ-007 SHALL have port go_to_standby_pulse  output  1  one-cycle pulse on acceptance of 01.
REQ-008 SHALL have port start_scan_pulse  output  1  one-cycle pulse on acceptance of 10.
REQ-009 SHALL have port flush_pulse  output  1  one-cycle pulse on acceptance of 11.
REQ-010 SHALL have port ready_to_transfer  output  1  level, high while accepted code is 01.
REQ-011 SHALL have port accepted_code  output  2  currently accepted code.
REQ-012 SHALL have port proto_error  output  1  sticky illegal-transition flag.
REQ-013 SHALL have port event_count  output  COUNT_WIDTH  saturating count of accepted code changes.

Function
REQ-014 SHALL pass peer_comm through a two-flop synchronizer before any other use.
REQ-015 SHALL hold a candidate code and a stability counter; counter restarts at 1 whenever synchronized value differs from candidate.
REQ-016 SHALL accept candidate when it has matched for STABLE_CYCLES consecutive cycles and differs from accepted_code.
REQ-017 SHALL ignore glitches shorter than STABLE_CYCLES cycles; accepted_code unchanged, no pulse.
REQ-018 Latency: peer_comm stable before edge N SHALL update accepted_code and raise the matching pulse after edge N+STABLE_CYCLES+1 (edge N+3 at default), pulse high exactly one cycle.
REQ-019 SHALL raise no pulse on acceptance of 00; accepting 00 only updates accepted_code and event_count.
REQ-020 Legal transitions: 00->01, 01->10, 01->00, 10->11, 10->00, 11->00; all others SHALL set proto_error.
REQ-021 On an illegal transition, SHALL still update accepted_code and raise the matching pulse.
REQ-022 proto_error SHALL stay high until clear_error is sampled high; an illegal acceptance in the same cycle as clear_error SHALL leave proto_error high.
REQ-023 At most one pulse output SHALL be high in any cycle.
REQ-024 event_count SHALL increment by 1 per acceptance and saturate at all-ones, never wrapping.

Reset
REQ-025 reset low SHALL asynchronously force synchronizer flops, candidate and accepted_code to 00, stability counter to 0, all pulses, ready_to_transfer, proto_error and event_count to 0.
REQ-026 Reset asserted mid-acceptance SHALL discard the pending candidate; after release, a code held from reset already active SHALL need the full REQ-018 latency.
REQ-027 After reset release, peer_comm at 00 SHALL produce no pulse and no count.

Configuration
REQ-028 Macro SCAN_COMM_EVENT_COUNT_EN defined: event_count counter SHALL be built per REQ-024.
REQ-029 Macro SCAN_COMM_EVENT_COUNT_EN undefined: no counter flops SHALL be built and event_count SHALL be tied to 0; all other behaviour unchanged.

Verification
REQ-030 Reset release, peer_comm 00->01 before edge 5 -> go_to_standby_pulse high only after edge 8, ready_to_transfer high from edge 8, event_count=1.
REQ-031 Sequence 01,10,11,00, each held 6 cycles -> one pulse each for standby/scan/flush, no pulse for 00, proto_error=0, event_count=4.
REQ-032 From 00, 10 for 1 cycle, then back to 00 -> no pulse, accepted_code stays 00, event_count unchanged.
REQ-033 From 00, drive 11 for 6 cycles -> flush_pulse once, proto_error=1; assert clear_error 1 cycle -> proto_error=0 next cycle.
REQ-034 Hold 01/00 alternating 20 times with 4-bit counter, macro defined -> event_count saturates at 15; macro undefined -> event_count=0 throughout.
REQ-035 Drive 10 from 01, assert reset at edge N+2 (before acceptance) -> all outputs 0 immediately, no start_scan_pulse at any later edge while reset held.
